// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: PC, imem req/ack handshake, one-entry skid buffer, redirect/flush.
// Latency: imem_ack -> IF/ID outputs 1 cycle; branch_taken -> imem_addr=target 1 cycle.
// Backpressure: stall freezes IF/ID and PC; a word acked under stall parks in the skid (HOLD, no new requests).
// FETCH_ALIGN_CHECK_EN adds a sticky misalign_err output for redirect targets with bits[1:0] != 00.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruccion,
    output logic [31:0] pc_plus4,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic        misalign_err,
`endif
    output logic        if_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr_nxt, pc4_nxt;
    logic        vld_nxt;
    logic [31:0] skid_dat, skid_dat_nxt;
    logic [31:0] skid_pc4, skid_pc4_nxt;
    logic [31:0] pc_inc;
    logic [31:0] tgt_aligned;

    assign pc_inc      = pc + 32'd4;
    assign tgt_aligned = branch_target & ~32'd3;
    assign imem_addr   = pc;
    assign imem_req    = (state == REQ);

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        instr_nxt    = instruccion;
        pc4_nxt      = pc_plus4;
        vld_nxt      = if_valid;
        skid_dat_nxt = skid_dat;
        skid_pc4_nxt = skid_pc4;

        // Redirect wins over stall and ack; the skid is dropped simply by leaving HOLD.
        if (branch_taken) begin
            pc_nxt    = tgt_aligned;
            instr_nxt = NOP_WORD;
            vld_nxt   = 1'b0;
            state_nxt = REQ;
        end else begin
            case (state)
                IDLE: state_nxt = REQ;
                REQ: begin
                    if (imem_ack) begin
                        if (stall) begin
                            skid_dat_nxt = imem_rdata;
                            skid_pc4_nxt = pc_inc;
                            state_nxt    = HOLD;
                        end else begin
                            instr_nxt = imem_rdata;
                            pc4_nxt   = pc_inc;
                            vld_nxt   = 1'b1;
                            pc_nxt    = pc_inc;
                        end
                    end else if (!stall) begin
                        instr_nxt = NOP_WORD;
                        vld_nxt   = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_nxt = skid_dat;
                        pc4_nxt   = skid_pc4;
                        vld_nxt   = 1'b1;
                        pc_nxt    = skid_pc4;
                        state_nxt = REQ;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruccion <= NOP_WORD;
            pc_plus4    <= 32'd0;
            if_valid    <= 1'b0;
            skid_dat    <= 32'd0;
            skid_pc4    <= 32'd0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instruccion <= instr_nxt;
            pc_plus4    <= pc4_nxt;
            if_valid    <= vld_nxt;
            skid_dat    <= skid_dat_nxt;
            skid_pc4    <= skid_pc4_nxt;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_err <= 1'b0;
        end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan steps followed by random stall/ack/redirect traffic,
// each cycle compared against a transaction-level model of the fetch stream.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruccion;
    logic [31:0] pc_plus4;
    logic        if_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instruccion   (instruccion),
        .pc_plus4      (pc_plus4),
`ifdef FETCH_ALIGN_CHECK_EN
        .misalign_err  (misalign_err),
`endif
        .if_valid      (if_valid)
    );

    always #5 clk = ~clk;

    // Memory image: every word is its address XOR a fixed tag.
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    int tests = 0;
    int fails = 0;

    // Model: fetch pointer, whether the stage is still in its post-reset gap,
    // and whether one fetched-but-undelivered word is parked.
    logic        m_gap;
    logic        m_parked;
    logic [31:0] m_parked_addr;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_vld;
    logic        m_mis;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_gap         = 1'b1;
        m_parked      = 1'b0;
        m_parked_addr = 32'd0;
        m_pc          = 32'd0;
        m_instr       = 32'd0;
        m_pc4         = 32'd0;
        m_vld         = 1'b0;
        m_mis         = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] a);
        m_instr = mem_word(a);
        m_pc4   = a + 32'd4;
        m_vld   = 1'b1;
        m_pc    = a + 32'd4;
    endtask

    task automatic m_edge(input logic st, input logic br, input logic [31:0] tgt, input logic ak);
        if (br) begin
            m_pc     = {tgt[31:2], 2'b00};
            m_instr  = 32'd0;
            m_vld    = 1'b0;
            m_parked = 1'b0;
            m_gap    = 1'b0;
            if (tgt[1:0] != 2'b00) m_mis = 1'b1;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_parked) begin
            if (!st) begin
                deliver(m_parked_addr);
                m_parked = 1'b0;
            end
        end else if (ak) begin
            if (st) begin
                m_parked      = 1'b1;
                m_parked_addr = m_pc;
            end else begin
                deliver(m_pc);
            end
        end else if (!st) begin
            m_instr = 32'd0;
            m_vld   = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},  imem_addr, m_pc);
        chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, !m_gap && !m_parked && rst});
        chk({tag, ".instr"}, instruccion, m_instr);
        chk({tag, ".pc4"},   pc_plus4, m_pc4);
        chk({tag, ".vld"},   {31'd0, if_valid}, {31'd0, m_vld});
`ifdef FETCH_ALIGN_CHECK_EN
        chk({tag, ".mis"},   {31'd0, misalign_err}, {31'd0, m_mis});
`endif
    endtask

    task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                        input logic ak, input string tag);
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        imem_ack      = ak;
        @(posedge clk);
        #1;
        m_edge(st, br, tgt, ak);
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        imem_ack = 1'b1;
        m_reset();
        #2 rst = 1'b0;
        #10;
        check_all("reset");
        #10 rst = 1'b1;
        chk("gap_req", {31'd0, imem_req}, 32'd0);

        // Zero-wait memory
        step(1'b0, 1'b0, 32'd0, 1'b1, "gap");
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, "zw0");
        chk("zw_first_word", instruccion, 32'hA5A5_0000);
        chk("zw_first_pc4", pc_plus4, 32'd4);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b1, "zw");

        // Two wait states per fetch
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'd0, (i % 3) == 2, "ws");

        // Stall coincident with ack at 0x10
        step(1'b0, 1'b1, 32'h10, 1'b0, "br10");
        step(1'b1, 1'b0, 32'd0, 1'b1, "stall_ack");
        chk("stall_req", {31'd0, imem_req}, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, "stall2");
        step(1'b1, 1'b0, 32'd0, 1'b0, "stall3");
        step(1'b0, 1'b0, 32'd0, 1'b1, "release");
        chk("release_word", instruccion, 32'hA5A5_0010);
        chk("release_pc4", pc_plus4, 32'h14);
        chk("release_next", imem_addr, 32'h14);
        step(1'b0, 1'b0, 32'd0, 1'b1, "after_rel");
        chk("after_rel_word", instruccion, 32'hA5A5_0014);

        // Redirect while stalled and acked
        step(1'b1, 1'b1, 32'h40, 1'b1, "br_stall");
        chk("br_stall_vld", {31'd0, if_valid}, 32'd0);
        chk("br_stall_addr", imem_addr, 32'h40);
        step(1'b0, 1'b0, 32'd0, 1'b1, "br_tgt");
        chk("br_tgt_word", instruccion, 32'hA5A5_0040);
        chk("br_tgt_pc4", pc_plus4, 32'h44);

        // PC wrap
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, "br_top");
        step(1'b0, 1'b0, 32'd0, 1'b1, "wrap");
        chk("wrap_pc4", pc_plus4, 32'd0);
        chk("wrap_addr", imem_addr, 32'd0);

        // Asynchronous reset mid-REQ
        #2 rst = 1'b0;
        #1;
        m_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b1;

        // Misaligned redirect target
        step(1'b0, 1'b0, 32'd0, 1'b1, "post_rst");
        step(1'b0, 1'b1, 32'h43, 1'b1, "br43");
        chk("br43_addr", imem_addr, 32'h40);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b1, "post43");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        st, br, ak;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 11) == 0);
            ak  = ($urandom_range(0, 2) != 0);
            tgt = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(st, br, tgt, ak, "rnd");
        end

        // Reset clears everything, including the sticky error
        #2 rst = 1'b0;
        #1;
        m_reset();
        check_all("final_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
